tx_serializer: RTL and testbench
================================

# tx_serializer

Serial output stage downstream of the 7-bit rotate unit. Accepts the rotated 7-bit word over a valid/ready handshake and holds it in a one-entry buffer. Transmits each word as a framed serial stream on `tx`: start bit, 7 data bits LSB-first, optional parity bit, stop bit. A new word can be buffered while the current frame is still being sent, so back-to-back frames leave no idle gap.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 1..255.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `din` input 7: word to transmit, normally the rotate unit's `result`.
- `din_valid` input 1: `din` is valid this cycle.
- `din_ready` output 1: the buffer is empty; combinational, equal to `!buf_full`.
- `tx` output 1: serial line; idles high.
- `busy` output 1: the FSM is not in IDLE.
- `done` output 1: one-cycle pulse after each frame's stop bit completes.

## Operation
- Handshake:
  - A word is accepted at an edge where `din_valid && din_ready`.
  - On acceptance, `din` is written to the buffer and `buf_full` is set.
  - There is no bypass. If the buffer drains in a cycle, `din_ready` stays low for that cycle and rises the next cycle.
- FSM states are IDLE, START, DATA, PARITY (present only with the macro), and STOP.
- IDLE:
  - `tx`=1.
  - If `buf_full`: load the shift register from the buffer, clear `buf_full`, and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx` = `shreg[0]`.
  - After each `CLKS_PER_BIT` cycles, shift right and increment the bit index.
  - After bit index 6, go to PARITY, or to STOP if the macro is absent.
- PARITY: `tx` = even parity of the 7 loaded data bits (`^data`) for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - On the final cycle's edge: if `buf_full`, load the buffer, clear it, and go to START directly; otherwise go to IDLE.
  - In both cases, `done` is registered high for the next cycle only.
- Counters:
  - The bit-period counter counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on every state or bit change.
  - The bit index is 3 bits wide and counts 0..6.
- The `tx` output is driven from a register, so it is glitch-free.
- Reset (asynchronous, any state, including mid-frame):
  - FSM goes to IDLE; `tx`=1, `busy`=0, `done`=0.
  - `buf_full`=0, so `din_ready`=1.
  - Counters are cleared and the in-flight word and buffered word are discarded.
- The buffered word is never overwritten or duplicated. Each accepted word produces exactly one frame.

## Timing
- Frame length: 9×`CLKS_PER_BIT` cycles, or 10×`CLKS_PER_BIT` with parity.
- Latency:
  - Word accepted at edge E while IDLE: `tx` falls at edge E+1 and `busy` rises at E+1.
  - `din_ready` is low for the cycle after E, and high again from E+1 onward.
- `done` is high for the cycle after the stop bit's final cycle, in parallel with the first START cycle of a back-to-back frame.
- Throughput: one word per frame length. Sustained valid input is backpressured through `din_ready`.

## Configuration
- `TX_SERIALIZER_PARITY_EN`:
  - Defined: the PARITY state exists and an even-parity bit is inserted between the data bits and the stop bit; frames are 10 bits.
  - Undefined: no PARITY state; DATA goes straight to STOP; frames are 9 bits.

## Test plan
- **Reset:** assert `reset` for 2 cycles, then release → `tx`=1, `busy`=0, `done`=0, `din_ready`=1.
- **Single word:** `CLKS_PER_BIT`=4, `din`=7'h55, one-cycle valid at edge E, no parity.
  - `tx` sequence from E+1, 4 cycles each: 0, 1,0,1,0,1,0,1, 1.
  - `done` pulses at E+37; `busy` falls at E+37.
- **Back-to-back:** send 7'h01; while it is in DATA, send 7'h7F, which is accepted immediately.
  - `din_ready` stays low until the second word is loaded at the end of the first frame's stop bit.
  - The second start bit follows the first stop bit with zero idle cycles.
- **Backpressure:** hold `din_valid`=1 with changing `din` while the buffer is full → `din_ready`=0 and no word is lost or duplicated. Exactly the accepted words appear on `tx`, in order.
- **Mid-frame reset:** pulse `reset` during data bit 3 → `tx`=1 asynchronously, `busy`=0, buffer empty. Sending 7'h2A afterwards produces one clean, correct frame.
- **Parity (macro defined):**
  - 7'h07 → parity bit 1.
  - 7'h03 → parity bit 0.
  - Frame is 40 cycles at `CLKS_PER_BIT`=4, and `done` pulses at E+41.

Source files
------------

// File: rtl/tx_serializer.sv
// tx_serializer: buffered 7-bit framed serial transmitter; even parity bit enabled by TX_SERIALIZER_PARITY_EN
module tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_SERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [6:0] shreg_q, shreg_d;
  logic [6:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       last, load, accept;
`ifdef TX_SERIALIZER_PARITY_EN
  logic       par_q, par_d;
`endif
  assign din_ready = !buf_full_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign tx        = tx_q;
  // next-state, buffer handshake and registered line value derived from the next state
  always_comb begin
    last    = cnt_q == 8'(CLKS_PER_BIT - 1);
    accept  = din_valid && !buf_full_q;
    load    = 1'b0;
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (buf_full_q) begin
        load    = 1'b1;
        state_d = START;
      end
      START: if (last) state_d = DATA;
      DATA: if (last) begin
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd6) begin
          idx_d   = 3'd0;
`ifdef TX_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef TX_SERIALIZER_PARITY_EN
      PARITY: if (last) state_d = STOP;
`endif
      STOP: if (last) begin
        done_d  = 1'b1;
        load    = buf_full_q;
        state_d = buf_full_q ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) shreg_d = buf_q;
    buf_full_d = load ? 1'b0 : accept ? 1'b1 : buf_full_q;
    buf_d      = accept ? din : buf_q;
    cnt_d      = (state_q == IDLE || last) ? 8'd0 : cnt_q + 8'd1;
`ifdef TX_SERIALIZER_PARITY_EN
    par_d      = load ? ^buf_q : par_q;
    tx_d       = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
    tx_d       = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : 1'b1;
`endif
  end
  // state registers; reset abandons any frame in flight and empties the buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= 3'd0;
      shreg_q    <= 7'd0;
      buf_q      <= 7'd0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
`ifdef TX_SERIALIZER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: directed checks of framing, handshake, back-to-back, backpressure and reset
module tb_tx_serializer;
`ifdef TX_SERIALIZER_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  logic       clk, reset, din_valid, din_ready, tx, busy, done;
  logic [6:0] din;
  int         errors = 0;
  int         checks = 0;

  tx_serializer #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .tx(tx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [6:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 7) return d[k-1];
`ifdef TX_SERIALIZER_PARITY_EN
    if (k == 8) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic run_frame(input logic [6:0] d, input int from, input int to, input logic rdy);
    for (int i = from; i < to; i++) begin
      chk($sformatf("tx_%h[%0d]", d, i), tx, exp_bit(d, i / 4));
      chk($sformatf("rdy_%h[%0d]", d, i), din_ready, rdy);
      @(negedge clk);
    end
  endtask

  task automatic send_idle(input logic [6:0] d);
    din = d;
    din_valid = 1'b1;
    chk("acc_rdy", din_ready, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    chk("e_rdy", din_ready, 1'b0);
    chk("e_tx", tx, 1'b1);
    chk("e_busy", busy, 1'b0);
    @(negedge clk);
    chk("e1_busy", busy, 1'b1);
  endtask

  task automatic frame_end_idle(input string tag);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_tx"}, tx, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    din = 7'd0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdy", din_ready, 1'b1);
    @(negedge clk);
    send_idle(7'h55);
    run_frame(7'h55, 0, NB * 4, 1'b1);
    frame_end_idle("single");
    @(negedge clk);
    chk("single_done_low", done, 1'b0);
    send_idle(7'h01);
    run_frame(7'h01, 0, 10, 1'b1);
    din = 7'h7F;
    din_valid = 1'b1;
    chk("b2b_rdy_pre", din_ready, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    run_frame(7'h01, 11, NB * 4, 1'b0);
    chk("b2b_done", done, 1'b1);
    chk("b2b_tx_start", tx, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_rdy", din_ready, 1'b1);
    run_frame(7'h7F, 0, NB * 4, 1'b1);
    frame_end_idle("b2b");
    @(negedge clk);
    din = 7'h11;
    din_valid = 1'b1;
    chk("bp_rdy0", din_ready, 1'b1);
    @(negedge clk);
    chk("bp_rdy1", din_ready, 1'b0);
    chk("bp_busy1", busy, 1'b0);
    din = 7'h22;
    @(negedge clk);
    chk("bp_rdy2", din_ready, 1'b1);
    chk("bp_busy2", busy, 1'b1);
    chk("bp_tx2", tx, 1'b0);
    din = 7'h33;
    @(negedge clk);
    chk("bp_rdy3", din_ready, 1'b0);
    din = 7'h44;
    @(negedge clk);
    run_frame(7'h11, 2, NB * 4, 1'b0);
    din_valid = 1'b0;
    chk("bp_done", done, 1'b1);
    chk("bp_tx_start", tx, 1'b0);
    chk("bp_rdy_load", din_ready, 1'b1);
    run_frame(7'h33, 0, NB * 4, 1'b1);
    frame_end_idle("bp");
    repeat (2) @(negedge clk);
    chk("bp_no_dup_busy", busy, 1'b0);
    chk("bp_no_dup_tx", tx, 1'b1);
    send_idle(7'h2A);
    run_frame(7'h2A, 0, 17, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rdy", din_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_done", done, 1'b0);
    @(negedge clk);
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    send_idle(7'h2A);
    run_frame(7'h2A, 0, NB * 4, 1'b1);
    frame_end_idle("after_rst");
    @(negedge clk);
`ifdef TX_SERIALIZER_PARITY_EN
    send_idle(7'h07);
    run_frame(7'h07, 0, 32, 1'b1);
    chk("par07", tx, 1'b1);
    run_frame(7'h07, 32, NB * 4, 1'b1);
    frame_end_idle("par07_end");
    @(negedge clk);
    send_idle(7'h03);
    run_frame(7'h03, 0, 32, 1'b1);
    chk("par03", tx, 1'b0);
    run_frame(7'h03, 32, NB * 4, 1'b1);
    frame_end_idle("par03_end");
    @(negedge clk);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
